// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: sequencer state encoding and default address/instruction widths
package cpu_seq_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, UPDATE, HALT, FAULT} seq_state_e;
endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory fetch handshake between sequencer (master) and memory (slave)
interface fetch_sequencer_if import cpu_seq_pkg::*; #(parameter int AW = AW_DEF, parameter int DW = DW_DEF);
  logic mem_req;
  logic [AW-1:0] mem_addr;
  logic mem_ack;
  logic [DW-1:0] mem_rdata;
  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_timer.sv
// fetch_timer: counts unacknowledged fetch cycles; expired flags the WAIT_MAX-th one
module fetch_timer import cpu_seq_pkg::*; #(parameter int WAIT_MAX = 15) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  assign expired = en && cnt_q == CW'(WAIT_MAX - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: FETCH/DECODE/EXEC/UPDATE sequencer owning pc and retired count.
// SINGLE_STEP_EN adds step_mode/step ports for halting after every instruction.
module fetch_sequencer import cpu_seq_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  fetch_sequencer_if.master mem,
  output logic [DW-1:0] ir,
  output logic ir_valid,
  input  logic exec_done,
  input  logic branch_taken,
  input  logic [AW-1:0] branch_target,
  input  logic halt_req,
`ifdef SINGLE_STEP_EN
  input  logic step_mode,
  input  logic step,
`endif
  output logic halted,
  output logic fault,
  output logic [AW-1:0] pc,
  output logic [7:0] instr_count
);
  seq_state_e state_q, state_d;
  logic run_q;
  logic [AW-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [7:0] cnt_q, cnt_d;
  logic br_q, br_d, wait_en, expired, fetched, latch, stop, resume;
  // run_q keeps mem_req low until the first clock after reset release
  assign mem.mem_req = run_q && state_q == FETCH;
  assign mem.mem_addr = pc_q;
  assign fetched = mem.mem_req && mem.mem_ack;
  assign wait_en = mem.mem_req && !mem.mem_ack;
  assign latch = state_q == EXEC && exec_done;
`ifdef SINGLE_STEP_EN
  assign stop = halt_req || step_mode;
  assign resume = !halt_req && (!step_mode || step);
`else
  assign stop = halt_req;
  assign resume = !halt_req;
`endif
  fetch_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (.clk, .rst, .clr(!wait_en), .en(wait_en), .expired);
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = expired ? FAULT : fetched ? DECODE : FETCH;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = exec_done ? UPDATE : EXEC;
      UPDATE:  state_d = stop ? HALT : FETCH;
      HALT:    state_d = resume ? FETCH : HALT;
      default: state_d = FAULT;
    endcase
  end
  always_comb begin
    pc_d = state_q == UPDATE ? (br_q ? tgt_q : pc_q + AW'(1)) : pc_q;
    cnt_d = state_q == UPDATE ? cnt_q + 8'd1 : cnt_q;
    ir_d = fetched ? mem.mem_rdata : ir_q;
    br_d = latch ? branch_taken : br_q;
    tgt_d = latch ? branch_target : tgt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= FETCH;
      run_q <= 1'b0;
      pc_q <= '0;
      cnt_q <= '0;
      ir_q <= '0;
      br_q <= 1'b0;
      tgt_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= 1'b1;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      ir_q <= ir_d;
      br_q <= br_d;
      tgt_q <= tgt_d;
    end
  assign ir = ir_q;
  assign ir_valid = state_q == DECODE;
  assign halted = state_q == HALT;
  assign fault = state_q == FAULT;
  assign pc = pc_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized instruction cycles checked against an arithmetic pc/count model
module tb_fetch_sequencer;
  localparam int WM = 15;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] ir, pc, instr_count, branch_target = '0;
  logic ir_valid, halted, fault;
  logic exec_done = 1'b0, branch_taken = 1'b0, halt_req = 1'b0;
`ifdef SINGLE_STEP_EN
  logic step_mode = 1'b0, step = 1'b0;
`endif
  int checks = 0, errors = 0;
  logic [7:0] m_pc, m_cnt;
  fetch_sequencer_if #(.AW(8), .DW(8)) mem_if ();
  fetch_sequencer #(.AW(8), .DW(8), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst), .mem(mem_if), .ir(ir), .ir_valid(ir_valid),
    .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req),
`ifdef SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .halted(halted), .fault(fault), .pc(pc), .instr_count(instr_count)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the first negedge with mem_req expected high.
  task automatic do_reset;
    rst = 1'b1;
    mem_if.mem_ack = 1'b0;
    exec_done = 1'b0;
    halt_req = 1'b0;
    #1;
    chk("rst_req", mem_if.mem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_ir", ir, 0);
    chk("rst_irv", ir_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("req_after_release", mem_if.mem_req, 0);
    @(negedge clk);
    chk("req_first", mem_if.mem_req, 1);
    chk("addr_first", mem_if.mem_addr, 0);
    m_pc = 8'h00;
    m_cnt = 8'h00;
  endtask

  // One full instruction starting at a FETCH negedge with mem_req high.
  task automatic do_instr(input int ack_dly, input bit tk, input logic [7:0] tgt, input int ex_dly, input bit hreq);
    logic [7:0] data;
    bit exp_halt;
    data = 8'($urandom);
    for (int i = 0; i < ack_dly; i++) begin
      chk("req_hold", mem_if.mem_req, 1);
      chk("addr_hold", mem_if.mem_addr, m_pc);
      mem_if.mem_ack = 1'b0;
      mem_if.mem_rdata = 8'($urandom);
      halt_req = 1'($urandom);
      @(negedge clk);
    end
    chk("req_ack", mem_if.mem_req, 1);
    chk("addr_ack", mem_if.mem_addr, m_pc);
    mem_if.mem_ack = 1'b1;
    mem_if.mem_rdata = data;
    halt_req = 1'b0;
    @(negedge clk);
    mem_if.mem_ack = 1'($urandom);
    mem_if.mem_rdata = 8'($urandom);
    chk("irv_decode", ir_valid, 1);
    chk("ir_data", ir, data);
    chk("req_decode", mem_if.mem_req, 0);
    @(negedge clk);
    chk("irv_exec", ir_valid, 0);
    for (int i = 0; i < ex_dly; i++) begin
      exec_done = 1'b0;
      branch_taken = 1'($urandom);
      branch_target = 8'($urandom);
      halt_req = 1'($urandom);
      @(negedge clk);
    end
    exec_done = 1'b1;
    branch_taken = tk;
    branch_target = tgt;
    halt_req = hreq;
    @(negedge clk);
    exec_done = 1'b0;
    branch_taken = 1'($urandom);
    branch_target = 8'($urandom);
    mem_if.mem_ack = 1'b0;
    @(negedge clk);
    m_pc = tk ? tgt : m_pc + 8'd1;
    m_cnt = m_cnt + 8'd1;
    exp_halt = hreq;
`ifdef SINGLE_STEP_EN
    exp_halt = hreq || step_mode;
`endif
    chk("pc_upd", pc, m_pc);
    chk("cnt_upd", instr_count, m_cnt);
    chk("halted_upd", halted, exp_halt);
    chk("req_next", mem_if.mem_req, !exp_halt);
    if (exp_halt) begin
      repeat (2) begin
        @(negedge clk);
        chk("halt_hold", halted, 1);
        chk("halt_pc", pc, m_pc);
      end
      halt_req = 1'b0;
`ifdef SINGLE_STEP_EN
      if (step_mode) begin
        @(negedge clk);
        chk("step_wait", halted, 1);
        step = 1'b1;
      end
`endif
      @(negedge clk);
`ifdef SINGLE_STEP_EN
      step = 1'b0;
`endif
      chk("resume", halted, 0);
      chk("resume_addr", mem_if.mem_addr, m_pc);
    end
  endtask

  initial begin
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = '0;
    @(negedge clk);
    do_reset();
    repeat (3) do_instr(0, 0, 0, 0, 0);
    chk("cnt_three", instr_count, 3);
    do_instr(0, 0, 0, 1, 0);
    do_instr(0, 0, 0, 0, 0);
    chk("pc_five", pc, 8'h05);
    do_instr(0, 1, 8'h40, 0, 0);
    chk("branch_addr", mem_if.mem_addr, 8'h40);
    do_instr(0, 1, 8'hFF, 0, 0);
    do_instr(0, 0, 0, 0, 0);
    chk("wrap_addr", mem_if.mem_addr, 8'h00);
    do_instr(3, 0, 0, 2, 0);
    do_instr(WM - 1, 0, 0, 0, 0);
    do_instr(1, 0, 0, 2, 1);
    for (int n = 0; n < 260; n++)
      do_instr(int'($urandom_range(0, 5)), 1'($urandom), 8'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    mem_if.mem_ack = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", mem_if.mem_req, 1);
    #2;
    do_reset();
    for (int i = 0; i < WM; i++) begin
      chk("fault_wait_req", mem_if.mem_req, 1);
      chk("fault_wait_flag", fault, 0);
      @(negedge clk);
    end
    chk("fault_set", fault, 1);
    chk("fault_req", mem_if.mem_req, 0);
    mem_if.mem_ack = 1'b1;
    halt_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("fault_sticky", fault, 1);
    mem_if.mem_ack = 1'b0;
    do_reset();
    chk("fault_cleared", fault, 0);
    do_instr(0, 0, 0, 0, 0);
`ifdef SINGLE_STEP_EN
    step_mode = 1'b1;
    do_instr(0, 0, 0, 0, 0);
    do_instr(2, 1, 8'h22, 1, 0);
    step_mode = 1'b0;
    do_instr(0, 0, 0, 0, 0);
    chk("step_cnt", instr_count, m_cnt);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
